nco_ctrl_regs: RTL and testbench

NCO_CTRL_REGS -- requirements
Module: nco_ctrl_regs

---
 rtl/nco_ctrl_regs.sv | 199 +++++++++++++++++++
 tb/tb_nco_ctrl_regs.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_ctrl_regs.sv
// nco_ctrl_regs: AXI4-Lite control registers for the DSM NCO core.
// Ports:
//   aclk, rst        - clock and synchronous active-high reset
//   s_axil_aw*/w*/b* - AXI4-Lite write channels (buffered AW and W)
//   s_axil_ar*/r*    - AXI4-Lite read channels
//   nco_step         - committed phase step
//   nco_step_enable  - CTRL bit 0
//   dither_enable    - CTRL bit 1
//   nco_step_update  - one-cycle pulse after a STEP commit
// Map: 0x0 STEP, 0x4 CTRL, 0x8 UPDCNT (RO), 0xC ID (RO).
module nco_ctrl_regs #(
    parameter int          ACC_WIDTH  = 32,
    parameter int          ADDR_WIDTH = 4,
    parameter logic [31:0] ID_VALUE   = 32'h4E43_4F31
) (
    input  logic                  aclk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [31:0]           s_axil_wdata,
    input  logic [3:0]            s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [31:0]           s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [ACC_WIDTH-1:0]  nco_step,
    output logic                  nco_step_enable,
    output logic                  dither_enable,
    output logic                  nco_step_update
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte lanes that actually land inside the STEP register.
    localparam int         NBYTES     = (ACC_WIDTH + 7) / 8;
    localparam logic [3:0] STEP_BYTES = 4'((1 << NBYTES) - 1);

    logic                  aw_full;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic                  w_full;
    logic [31:0]           w_data_q;
    logic [3:0]            w_strb_q;

    logic [ACC_WIDTH-1:0]  step_q;
    logic [1:0]            ctrl_q;
    logic [31:0]           updcnt_q;
    logic                  upd_q;

    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  rvalid_q;
    logic [31:0]           rdata_q;
    logic [1:0]            rresp_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic [31:0]           wr_a32;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic                  wr_mapped;
    logic                  step_we;
    logic                  ctrl_we;
    logic                  step_upd;
    logic                  wr_ok;
    logic [31:0]           step_new;
    logic [31:0]           rd_a32;
    logic [31:0]           rd_data_n;
    logic [1:0]            rd_resp_n;

    // Readies are forced low while reset is asserted.
    assign s_axil_awready = ~rst & ~aw_full & ~bvalid_q;
    assign s_axil_wready  = ~rst & ~w_full & ~bvalid_q;
    assign s_axil_arready = ~rst & ~rvalid_q;

    assign aw_hs = s_axil_awvalid & s_axil_awready;
    assign w_hs  = s_axil_wvalid & s_axil_wready;
    assign ar_hs = s_axil_arvalid & s_axil_arready;

    // A beat being accepted counts as present, so the write commits
    // in the same cycle the second half of the pair arrives.
    assign commit = (aw_full | aw_hs) & (w_full | w_hs);

    assign wr_a32  = aw_full ? 32'(aw_addr_q) : 32'(s_axil_awaddr);
    assign wr_data = w_full ? w_data_q : s_axil_wdata;
    assign wr_strb = w_full ? w_strb_q : s_axil_wstrb;

    assign wr_mapped = (wr_a32[31:4] == 28'd0);
    assign step_we   = commit & wr_mapped & (wr_a32[3:2] == 2'd0);
    assign ctrl_we   = commit & wr_mapped & (wr_a32[3:2] == 2'd1);
    assign step_upd  = step_we & (|(wr_strb & STEP_BYTES));
    assign wr_ok     = wr_mapped & ~wr_a32[3];

    always_comb begin
        step_new = 32'(step_q);
        for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) begin
                step_new[b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

    assign rd_a32 = 32'(s_axil_araddr);

    always_comb begin
        rd_data_n = 32'd0;
        rd_resp_n = RESP_SLVERR;
        if (rd_a32[31:4] == 28'd0) begin
            rd_resp_n = RESP_OKAY;
            unique case (rd_a32[3:2])
                2'd0:    rd_data_n = 32'(step_q);
                2'd1:    rd_data_n = {30'd0, ctrl_q};
                2'd2:    rd_data_n = updcnt_q;
                default: rd_data_n = ID_VALUE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            aw_full   <= 1'b0;
            aw_addr_q <= '0;
            w_full    <= 1'b0;
            w_data_q  <= 32'd0;
            w_strb_q  <= 4'd0;
            step_q    <= '0;
            ctrl_q    <= 2'b01;
            updcnt_q  <= 32'd0;
            upd_q     <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_addr_q <= s_axil_awaddr;
            end
            if (w_hs) begin
                w_data_q <= s_axil_wdata;
                w_strb_q <= s_axil_wstrb;
            end

            if (commit) begin
                aw_full  <= 1'b0;
                w_full   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) aw_full <= 1'b1;
                if (w_hs)  w_full  <= 1'b1;
                if (bvalid_q & s_axil_bready) begin
                    bvalid_q <= 1'b0;
                end
            end

            if (step_we) begin
                step_q <= step_new[ACC_WIDTH-1:0];
            end
            if (ctrl_we & wr_strb[0]) begin
                ctrl_q <= wr_data[1:0];
            end
            upd_q <= step_upd;
            if (step_upd) begin
                updcnt_q <= updcnt_q + 32'd1;
            end

            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data_n;
                rresp_q  <= rd_resp_n;
            end else if (rvalid_q & s_axil_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s_axil_bvalid   = bvalid_q;
    assign s_axil_bresp    = bresp_q;
    assign s_axil_rvalid   = rvalid_q;
    assign s_axil_rdata    = rdata_q;
    assign s_axil_rresp    = rresp_q;
    assign nco_step        = step_q;
    assign nco_step_enable = ctrl_q[0];
    assign dither_enable   = ctrl_q[1];
    assign nco_step_update = upd_q;

endmodule

// File: tb/tb_nco_ctrl_regs.sv
// tb_nco_ctrl_regs: directed and random bench for nco_ctrl_regs.
// Transaction-level model with queues; compared every cycle.
module tb_nco_ctrl_regs;

    localparam int          AW  = 5;
    localparam logic [31:0] IDV = 32'h4E43_4F31;

    logic          aclk = 1'b0;
    logic          rst;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic [31:0]   step;
    logic          step_en;
    logic          dith_en;
    logic          step_upd;

    int n_cmp = 0;
    int n_bad = 0;

    nco_ctrl_regs #(
        .ACC_WIDTH (32),
        .ADDR_WIDTH(AW),
        .ID_VALUE  (IDV)
    ) dut (
        .aclk           (aclk),
        .rst            (rst),
        .s_axil_awaddr  (awaddr),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .nco_step       (step),
        .nco_step_enable(step_en),
        .dither_enable  (dith_en),
        .nco_step_update(step_upd)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h",
                     nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_valid = 1'b0;
    logic [4:0]  m_aw_q[$];
    logic [35:0] m_w_q[$];
    logic [31:0] m_step;
    logic [1:0]  m_ctrl;
    logic [31:0] m_cnt;
    bit          m_upd;
    bit          m_bv;
    logic [1:0]  m_br;
    bit          m_rv;
    logic [31:0] m_rd;
    logic [1:0]  m_rr;

    function automatic bit m_awr();
        return !rst && m_aw_q.size() == 0 && !m_bv;
    endfunction

    function automatic bit m_wr();
        return !rst && m_w_q.size() == 0 && !m_bv;
    endfunction

    function automatic bit m_arr();
        return !rst && !m_rv;
    endfunction

    function automatic void m_read(input logic [4:0] a,
                                   output logic [31:0] d,
                                   output logic [1:0] r);
        int idx;
        idx = int'(a) / 4;
        r = 2'b00;
        case (idx)
            0:       d = m_step;
            1:       d = {30'd0, m_ctrl};
            2:       d = m_cnt;
            3:       d = IDV;
            default: begin d = 32'd0; r = 2'b10; end
        endcase
    endfunction

    function automatic void m_write(input logic [4:0] a,
                                    input logic [31:0] d,
                                    input logic [3:0] s);
        int idx;
        idx = int'(a) / 4;
        m_br = (idx <= 1) ? 2'b00 : 2'b10;
        if (idx == 0) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_step[b*8 +: 8] = d[b*8 +: 8];
            if (s != 4'd0) begin
                m_upd = 1'b1;
                m_cnt = m_cnt + 1;
            end
        end else if (idx == 1 && s[0]) begin
            m_ctrl = d[1:0];
        end
    endfunction

    always @(posedge aclk) begin
        bit awr;
        bit wrr;
        bit arr;
        logic [4:0]  ca;
        logic [35:0] cw;
        awr = m_awr();
        wrr = m_wr();
        arr = m_arr();
        if (rst) begin
            m_valid = 1'b1;
            m_aw_q.delete();
            m_w_q.delete();
            m_step = 32'd0;
            m_ctrl = 2'b01;
            m_cnt  = 32'd0;
            m_upd  = 1'b0;
            m_bv   = 1'b0;
            m_br   = 2'b00;
            m_rv   = 1'b0;
        end else begin
            m_upd = 1'b0;
            if (m_rv && rready) m_rv = 1'b0;
            else if (arr && arvalid) begin
                m_read(araddr, m_rd, m_rr);
                m_rv = 1'b1;
            end
            if (m_bv && bready) m_bv = 1'b0;
            if (awr && awvalid) m_aw_q.push_back(awaddr);
            if (wrr && wvalid) m_w_q.push_back({wstrb, wdata});
            if (m_aw_q.size() > 0 && m_w_q.size() > 0) begin
                ca = m_aw_q.pop_front();
                cw = m_w_q.pop_front();
                m_write(ca, cw[31:0], cw[35:32]);
                m_bv = 1'b1;
            end
        end
    end

    always @(negedge aclk) begin
        if (m_valid) begin
            chk("awready", 32'(awready), 32'(m_awr()));
            chk("wready", 32'(wready), 32'(m_wr()));
            chk("arready", 32'(arready), 32'(m_arr()));
            chk("bvalid", 32'(bvalid), 32'(m_bv));
            if (m_bv) chk("bresp", 32'(bresp), 32'(m_br));
            chk("rvalid", 32'(rvalid), 32'(m_rv));
            if (m_rv) begin
                chk("rdata", rdata, m_rd);
                chk("rresp", 32'(rresp), 32'(m_rr));
            end
            chk("nco_step", step, m_step);
            chk("step_en", 32'(step_en), 32'(m_ctrl[0]));
            chk("dither", 32'(dith_en), 32'(m_ctrl[1]));
            chk("step_upd", 32'(step_upd), 32'(m_upd));
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        awaddr  = '0;
        araddr  = '0;
        wdata   = 32'd0;
        wstrb   = 4'd0;
        bready  = 1'b1;
        rready  = 1'b1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        awvalid = 1'b1;
        awaddr  = a;
        wvalid  = 1'b1;
        wdata   = d;
        wstrb   = s;
        nxt();
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        arvalid = 1'b1;
        araddr  = a;
        nxt();
        arvalid = 1'b0;
    endtask

    function automatic logic [4:0] rnd_addr();
        int k;
        k = int'($urandom_range(0, 9));
        if (k < 4) return 5'($urandom_range(0, 3));
        if (k < 6) return 5'($urandom_range(4, 7));
        if (k < 8) return 5'($urandom_range(8, 15));
        return 5'($urandom_range(16, 31));
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        nxt();
        @(negedge aclk);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        nxt();
        rst = 1'b0;
        @(negedge aclk);
        chk("post_rst_awready", 32'(awready), 32'd1);
        chk("post_rst_step", step, 32'd0);
        chk("post_rst_en", 32'(step_en), 32'd1);

        // AW and W together to STEP
        nxt();
        bready = 1'b0;
        wr(5'h0, 32'h0012_3456, 4'hF);
        @(negedge aclk);
        chk("t28_bvalid", 32'(bvalid), 32'd1);
        chk("t28_bresp", 32'(bresp), 32'd0);
        chk("t28_step", step, 32'h0012_3456);
        chk("t28_upd", 32'(step_upd), 32'd1);
        nxt();
        bready = 1'b1;
        rready = 1'b0;
        rd(5'h8);
        @(negedge aclk);
        chk("t28_updcnt", rdata, 32'd1);
        chk("t28_bvalid_clr", 32'(bvalid), 32'd0);
        nxt();
        rready = 1'b1;
        nxt();

        // W early, AW three cycles later to CTRL
        wvalid = 1'b1;
        awaddr = 5'h4;
        wdata  = 32'h2;
        wstrb  = 4'hF;
        @(negedge aclk);
        chk("t29_c0_dith", 32'(dith_en), 32'd0);
        nxt();
        wvalid = 1'b0;
        @(negedge aclk);
        chk("t29_c1_bvalid", 32'(bvalid), 32'd0);
        chk("t29_c1_wready", 32'(wready), 32'd0);
        nxt();
        @(negedge aclk);
        chk("t29_c2_en", 32'(step_en), 32'd1);
        nxt();
        awvalid = 1'b1;
        @(negedge aclk);
        chk("t29_c3_dith", 32'(dith_en), 32'd0);
        nxt();
        awvalid = 1'b0;
        @(negedge aclk);
        chk("t29_c4_dith", 32'(dith_en), 32'd1);
        chk("t29_c4_en", 32'(step_en), 32'd0);
        nxt();

        // Byte strobes
        wr(5'h0, 32'hAABB_CCDD, 4'hF);
        nxt();
        wr(5'h0, 32'h1122_3344, 4'h5);
        @(negedge aclk);
        chk("t30_step", step, 32'hAA22_CC44);
        chk("t30_model", m_step, 32'hAA22_CC44);
        nxt();

        // Error responses and ID
        wr(5'hC, 32'h1234_5678, 4'hF);
        @(negedge aclk);
        chk("t31_bresp", 32'(bresp), 32'd2);
        nxt();
        rd(5'h10);
        @(negedge aclk);
        chk("t31_unm_rdata", rdata, 32'd0);
        chk("t31_unm_rresp", 32'(rresp), 32'd2);
        nxt();
        rd(5'hC);
        @(negedge aclk);
        chk("t31_id", rdata, IDV);
        chk("t31_id_rresp", 32'(rresp), 32'd0);
        nxt();

        // Back-pressure on B and R
        bready = 1'b0;
        wr(5'h4, 32'h1, 4'hF);
        for (int k = 0; k < 5; k++) begin
            awvalid = 1'b1;
            wvalid  = 1'b1;
            awaddr  = 5'h0;
            @(negedge aclk);
            chk("t32_bvalid", 32'(bvalid), 32'd1);
            chk("t32_bresp", 32'(bresp), 32'd0);
            chk("t32_awready", 32'(awready), 32'd0);
            chk("t32_wready", 32'(wready), 32'd0);
            nxt();
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        nxt();
        @(negedge aclk);
        chk("t32_bvalid_clr", 32'(bvalid), 32'd0);
        rready = 1'b0;
        rd(5'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            chk("t32_rvalid", 32'(rvalid), 32'd1);
            chk("t32_rdata", rdata, 32'hAA22_CC44);
            nxt();
        end
        rready = 1'b1;
        nxt();
        @(negedge aclk);
        chk("t32_rvalid_clr", 32'(rvalid), 32'd0);

        // Reset with a buffered AW and a pending read
        nxt();
        awvalid = 1'b1;
        awaddr  = 5'h0;
        arvalid = 1'b1;
        araddr  = 5'h0;
        rready  = 1'b0;
        nxt();
        awvalid = 1'b0;
        arvalid = 1'b0;
        @(negedge aclk);
        chk("t33_rvalid", 32'(rvalid), 32'd1);
        chk("t33_awready", 32'(awready), 32'd0);
        nxt();
        rst = 1'b1;
        @(negedge aclk);
        chk("t33_rst_wready", 32'(wready), 32'd0);
        nxt();
        rst    = 1'b0;
        rready = 1'b1;
        @(negedge aclk);
        chk("t33_rvalid_clr", 32'(rvalid), 32'd0);
        chk("t33_step", step, 32'd0);
        chk("t33_awready", 32'(awready), 32'd1);
        nxt();
        wvalid = 1'b1;
        wdata  = 32'h5A5A_5A5A;
        wstrb  = 4'hF;
        nxt();
        wvalid = 1'b0;
        @(negedge aclk);
        chk("t33_nocommit", 32'(bvalid), 32'd0);
        nxt();
        awvalid = 1'b1;
        awaddr  = 5'h0;
        nxt();
        awvalid = 1'b0;
        @(negedge aclk);
        chk("t33_commit", step, 32'h5A5A_5A5A);
        nxt();
        rd(5'h8);
        @(negedge aclk);
        chk("t33_updcnt", rdata, 32'd1);
        nxt();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 399) == 0);
            awvalid = ($urandom_range(0, 2) == 0);
            awaddr  = rnd_addr();
            wvalid  = ($urandom_range(0, 2) == 0);
            wdata   = $urandom();
            wstrb   = ($urandom_range(0, 7) == 0) ? 4'd0
                                                  : 4'($urandom_range(1, 15));
            bready  = ($urandom_range(0, 3) != 0);
            arvalid = ($urandom_range(0, 2) == 0);
            araddr  = rnd_addr();
            rready  = ($urandom_range(0, 3) != 0);
            nxt();
        end
        rst = 1'b0;
        idle();
        repeat (4) nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
